// File: rtl/seq101_tx.sv
// rtl/seq101_tx.sv - serial 101-pattern transmitter with per-frame match count
module seq101_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    // hist[1] is the bit two cycles before the one on out, hist[0] the previous one
    logic [1:0]       hist;

    // Ready is gated by reset directly so no word can be taken while reset is asserted
    assign data_ready = (state == S_IDLE) && !reset;

    // Frame sequencer: accept, shift out MSB first, count 101 triples, then idle gap
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            hist      <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            match_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (data_valid) begin
                        state     <= S_SHIFT;
                        out       <= data_in[WIDTH-1];
                        out_valid <= 1'b1;
                        shreg     <= {data_in[WIDTH-2:0], 1'b0};
                        bit_cnt   <= BW'(1);
                        hist      <= '0;
                        match_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    // The bit on out now closes a triple with the two history bits
                    hist <= {hist[0], out};
                    if (hist == 2'b10 && out && match_cnt != {CNT_W{1'b1}}) begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                    if (bit_cnt == BW'(WIDTH)) begin
                        state     <= S_GAP;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        gap_cnt   <= GW'(1);
                    end else begin
                        out     <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    hist <= '0;
                    if (gap_cnt == GW'(GAP)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq101_tx.sv
// tb/tb_seq101_tx.sv - self-checking bench for seq101_tx
module tb_seq101_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             out;
    logic             out_valid;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    // Free-running detector history on the raw serial line
    logic [2:0] det_hist = 3'b000;

    seq101_tx #(.WIDTH(WIDTH), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out        (out),
        .out_valid  (out_valid),
        .done       (done),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    // Count overlapping 101 windows reading the word MSB first, saturating
    function automatic int model_count(input logic [WIDTH-1:0] w);
        int n = 0;
        for (int i = WIDTH - 1; i >= 2; i--) begin
            if (w[i] == 1'b1 && w[i-1] == 1'b0 && w[i-2] == 1'b1) n++;
        end
        if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready (bounded), presents one word, returns in cycle 1 of the frame
    task automatic send_word(input logic [WIDTH-1:0] w);
        int budget = 0;
        while (!data_ready && budget < 30) begin
            step();
            budget++;
        end
        if (!data_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: data_ready=%b required 1", data_ready);
        end
        data_in    = w;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hA5;
        step();
        step();
        checks++;
        if (out !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out=%b out_valid=%b done=%b required 0 0 0", out, out_valid, done);
        end
        checks++;
        if (match_cnt !== '0) begin
            errors++;
            $display("FAIL reset_match_cnt: got %0d required 0", match_cnt);
        end
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", data_ready);
        end
        data_valid = 1'b0;
        reset      = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", data_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_transfer_in_reset: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_single_frame(input logic [WIDTH-1:0] w);
        int exp_cnt = model_count(w);
        send_word(w);
        for (int k = 1; k <= WIDTH; k++) begin
            checks++;
            if (out !== w[WIDTH-k] || out_valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL frame_bit word=%h k=%0d: out=%b out_valid=%b done=%b required %b 1 0",
                         w, k, out, out_valid, done, w[WIDTH-k]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || out !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_done word=%h: done=%b out=%b out_valid=%b required 1 0 0", w, done, out, out_valid);
        end
        checks++;
        if (match_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL frame_match_cnt word=%h: got %0d required %0d", w, match_cnt, exp_cnt);
        end
        step();
        checks++;
        if (done !== 1'b0 || match_cnt !== CNT_W'(exp_cnt) || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame_gap2 word=%h: done=%b match_cnt=%0d ready=%b required 0 %0d 0",
                     w, done, match_cnt, data_ready, exp_cnt);
        end
        step();
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_idle_ready word=%h: got %b required 1", w, data_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w1 = 8'hAD;
        logic [WIDTH-1:0] w2 = 8'hAA;
        data_in    = w1;
        data_valid = 1'b1;
        step();
        data_in = w2;
        for (int c = 1; c <= WIDTH + GAP; c++) begin
            if (c > WIDTH) begin
                checks++;
                if (out !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap c=%0d: out=%b out_valid=%b required 0 0", c, out, out_valid);
                end
            end
            checks++;
            if (data_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy c=%0d: ready=%b required 0", c, data_ready);
            end
            step();
        end
        checks++;
        if (data_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_cycle: ready=%b out_valid=%b required 1 0", data_ready, out_valid);
        end
        step();
        data_valid = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            checks++;
            if (out !== w2[WIDTH-k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second k=%0d: out=%b out_valid=%b required %b 1", k, out, out_valid, w2[WIDTH-k]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || match_cnt !== CNT_W'(model_count(w2))) begin
            errors++;
            $display("FAIL b2b_done: done=%b match_cnt=%0d required 1 %0d", done, match_cnt, model_count(w2));
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_frame();
        int saw_done = 0;
        send_word(8'hAD);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (out !== 1'b0 || out_valid !== 1'b0 || match_cnt !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: out=%b out_valid=%b match_cnt=%0d done=%b required 0 0 0 0",
                     out, out_valid, match_cnt, done);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b required 1", data_ready);
        end
        for (int c = 0; c < WIDTH + GAP + 2; c++) begin
            if (done === 1'b1 || out_valid === 1'b1) saw_done++;
            step();
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL midreset_no_done: activity cycles=%0d required 0", saw_done);
        end
    endtask

    task automatic test_ignore_during_shift();
        logic [WIDTH-1:0] w = WIDTH'($urandom);
        int bad = 0;
        send_word(w);
        for (int k = 1; k <= WIDTH; k++) begin
            if (out !== w[WIDTH-k] || out_valid !== 1'b1) bad++;
            data_in    = WIDTH'($urandom);
            data_valid = (k < WIDTH);
            step();
        end
        data_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_shift word=%h: bad bits=%0d required 0", w, bad);
        end
        checks++;
        if (done !== 1'b1 || match_cnt !== CNT_W'(model_count(w))) begin
            errors++;
            $display("FAIL ignore_shift_done word=%h: done=%b match_cnt=%0d required 1 %0d",
                     w, done, match_cnt, model_count(w));
        end
        step();
        step();
        checks++;
        if (data_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_shift_idle: ready=%b out_valid=%b required 1 0", data_ready, out_valid);
        end
    endtask

    task automatic test_loopback();
        int frame_errs = 0;
        for (int f = 0; f < 200; f++) begin
            logic [WIDTH-1:0] w = WIDTH'($urandom);
            int det_cnt = 0;
            int exp_cnt = model_count(w);
            send_word(w);
            for (int c = 1; c <= WIDTH + GAP; c++) begin
                det_hist = {det_hist[1:0], out};
                if (det_hist == 3'b101) det_cnt++;
                if (c == WIDTH + 1) begin
                    if (done !== 1'b1 || match_cnt !== CNT_W'(det_cnt) || det_cnt != exp_cnt) begin
                        frame_errs++;
                        if (frame_errs <= 5)
                            $display("FAIL loopback word=%h: done=%b match_cnt=%0d detector=%0d model=%0d",
                                     w, done, match_cnt, det_cnt, exp_cnt);
                    end
                end
                step();
            end
        end
        checks++;
        if (frame_errs != 0) begin
            errors++;
            $display("FAIL loopback_total: bad frames=%0d required 0", frame_errs);
        end
    endtask

    initial begin
        data_in    = '0;
        data_valid = 1'b0;
        reset      = 1'b1;
        step();
        test_reset();
        test_single_frame(8'b1010_1101);
        test_single_frame(8'hFF);
        test_single_frame(8'hAA);
        test_single_frame(8'h00);
        test_single_frame(WIDTH'($urandom));
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore_during_shift();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
